// File: rtl/jtframe_lfbuf_ring.sv
// rtl/jtframe_lfbuf_ring.sv - Parametrised line buffer ring between game renderer and video output
module jtframe_lfbuf_ring #(
    parameter int DW    = 16,
    parameter int HW    = 9,
    parameter int VW    = 8,
    parameter int LINES = 4,
    parameter int HLEN  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          lhbl,
    input  logic          lvbl,
    input  logic [HW-1:0] ln_addr,
    input  logic [DW-1:0] ln_data,
    input  logic          ln_we,
    input  logic          ln_done,
    output logic          ln_hs,
    output logic [VW-1:0] ln_v,
    output logic [DW-1:0] ln_pxl,
    input  logic [7:0]    st_addr,
    output logic [7:0]    st_dout
);
    localparam int SW = $clog2(LINES);
    localparam int FW = $clog2(LINES + 1);
    localparam int AW = $clog2(LINES * HLEN);
    localparam logic [FW-1:0] FULL    = FW'(LINES);
    localparam logic [FW-1:0] FULL_M1 = FW'(LINES - 1);
    localparam logic [HW:0]   HLEN_C  = (HW+1)'(HLEN);
    localparam logic [HW-1:0] HMAX    = HW'(HLEN - 1);

    logic [DW-1:0] mem [LINES*HLEN];
    logic [SW-1:0] wr_slot, rd_slot;
    logic [FW-1:0] fill, fill_nx;
    logic [HW-1:0] hcnt;
    logic [AW-1:0] wr_a, rd_a;
    logic          lhbl_l, lvbl_l, underrun, overrun, hs_pend;
    logic          lvbl_fall, lhbl_fall, done_ok, rel, hs_req, wr_ok, active;
    logic          st_unused;

    assign st_unused = ^st_addr[7:2];
    assign wr_a      = AW'(int'(wr_slot) * HLEN + int'(ln_addr));
    assign rd_a      = AW'(int'(rd_slot) * HLEN + int'(hcnt));
    assign active    = lhbl & lvbl;

    // Blanking edges, accepted line events, next occupancy and line-request decision
    always_comb begin
        lvbl_fall = lvbl_l & ~lvbl;
        lhbl_fall = lhbl_l & ~lhbl & lvbl;
        done_ok   = ln_done & (fill != FULL) & ~lvbl_fall;
        rel       = lhbl_fall & (fill != '0) & ~lvbl_fall;
        wr_ok     = ln_we & (fill != FULL) & ({1'b0, ln_addr} < HLEN_C);
        fill_nx   = fill;
        if (lvbl_fall)
            fill_nx = '0;
        else if (done_ok && !rel)
            fill_nx = fill + 1'b1;
        else if (rel && !done_ok)
            fill_nx = fill - 1'b1;
        // a released slot only needs a new request if the ring was full, i.e. nothing was pending
        hs_req = lvbl_fall
               | (done_ok & (rel | (fill < FULL_M1)))
               | (rel & ~done_ok & (fill == FULL));
    end

    // Line storage write port, kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_a] <= ln_data;
    end

    // Ring pointers, request pulses, pixel replay, sticky flags and status readout
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot  <= '0;
            rd_slot  <= '0;
            fill     <= '0;
            ln_v     <= '0;
            ln_hs    <= 1'b0;
            hs_pend  <= 1'b0;
            ln_pxl   <= '0;
            st_dout  <= '0;
            hcnt     <= '0;
            lhbl_l   <= 1'b0;
            lvbl_l   <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            lhbl_l <= lhbl;
            lvbl_l <= lvbl;
            fill   <= fill_nx;
            // a request colliding with a pulse in flight is deferred by one cycle
            ln_hs   <= (hs_req | hs_pend) & ~ln_hs & (fill_nx != FULL);
            hs_pend <= (hs_req | hs_pend) & ln_hs & (fill_nx != FULL);
            if (lvbl_fall) begin
                wr_slot <= '0;
                rd_slot <= '0;
                ln_v    <= '0;
            end else begin
                if (done_ok) begin
                    wr_slot <= wr_slot + 1'b1;
                    ln_v    <= ln_v + 1'b1;
                end
                if (rel)
                    rd_slot <= rd_slot + 1'b1;
            end
            if (!lhbl)
                hcnt <= '0;
            else if (pxl_cen && lvbl && hcnt != HMAX)
                hcnt <= hcnt + 1'b1;
            if (!active)
                ln_pxl <= '0;
            else if (pxl_cen)
                ln_pxl <= (fill == '0) ? '0 : mem[rd_a];
            // setting wins over the read-clear so no event is lost
            if (st_addr[1:0] == 2'd0) begin
                underrun <= 1'b0;
                overrun  <= 1'b0;
            end
            if (active && pxl_cen && fill == '0)
                underrun <= 1'b1;
            if (ln_done && fill == FULL && !lvbl_fall)
                overrun <= 1'b1;
            case (st_addr[1:0])
                2'd0:    st_dout <= {underrun, overrun, 2'b00, 4'(fill)};
                2'd1:    st_dout <= 8'(ln_v);
                2'd2:    st_dout <= {4'(wr_slot), 4'(rd_slot)};
                default: st_dout <= 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_lfbuf_ring.sv
// tb/tb_jtframe_lfbuf_ring.sv - Randomised bench for jtframe_lfbuf_ring against a line-queue model
module tb_jtframe_lfbuf_ring;
    localparam int DW = 16, HW = 9, VW = 8, LINES = 4, HLEN = 256;

    logic          clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, lhbl = 1'b0, lvbl = 1'b1;
    logic          ln_we = 1'b0, ln_done = 1'b0;
    logic [HW-1:0] ln_addr = '0;
    logic [DW-1:0] ln_data = '0;
    logic [7:0]    st_addr = 8'd1;
    logic          ln_hs;
    logic [VW-1:0] ln_v;
    logic [DW-1:0] ln_pxl;
    logic [7:0]    st_dout;

    jtframe_lfbuf_ring #(.DW(DW), .HW(HW), .VW(VW), .LINES(LINES), .HLEN(HLEN)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .lhbl(lhbl), .lvbl(lvbl),
        .ln_addr(ln_addr), .ln_data(ln_data), .ln_we(ln_we), .ln_done(ln_done),
        .ln_hs(ln_hs), .ln_v(ln_v), .ln_pxl(ln_pxl), .st_addr(st_addr), .st_dout(st_dout)
    );

    always #5 clk = ~clk;

    typedef logic [HLEN-1:0][DW-1:0] line_t;
    line_t         q[$];
    line_t         cur;
    int            m_v, m_wr, m_rd, m_pos, m_req, n_tests, n_fail;
    bit            m_under, m_over, prev_lvbl, prev_lhbl, prev_hs, rd0;
    logic [DW-1:0] exp_pxl;
    logic          exp_hs;
    logic [7:0]    exp_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit lvf, lhf, dok, rls;
        pxl_cen = 1'($urandom_range(0, 1));
        st_addr = rd0 ? (8'($urandom) & 8'hFC) : ((8'($urandom) & 8'hFC) | 8'($urandom_range(1, 3)));
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_v = 0; m_wr = 0; m_rd = 0; m_pos = 0; m_req = 1;
            m_under = 0; m_over = 0; prev_lvbl = 0; prev_lhbl = 0;
            exp_pxl = '0; exp_hs = 0; exp_st = '0;
        end else begin
            case (st_addr[1:0])
                2'd0:    exp_st = {m_under, m_over, 2'b00, 4'(q.size())};
                2'd1:    exp_st = 8'(m_v);
                2'd2:    exp_st = {4'(m_wr), 4'(m_rd)};
                default: exp_st = 8'h00;
            endcase
            if (st_addr[1:0] == 2'd0) begin
                m_under = 0;
                m_over  = 0;
            end
            if (!lhbl) m_pos = 0;
            if (!(lhbl && lvbl)) exp_pxl = '0;
            else if (pxl_cen) begin
                if (q.size() == 0) begin
                    exp_pxl = '0;
                    m_under = 1;
                end else exp_pxl = q[0][m_pos];
                if (m_pos < HLEN - 1) m_pos++;
            end
            if (ln_we && q.size() < LINES && ln_addr < HLEN) cur[ln_addr] = ln_data;
            lvf = prev_lvbl && !lvbl;
            lhf = prev_lhbl && !lhbl && lvbl;
            if (lvf) begin
                q.delete();
                m_v = 0; m_wr = 0; m_rd = 0; m_req = 0;
            end else begin
                dok = ln_done && q.size() < LINES;
                rls = lhf && q.size() > 0;
                if (ln_done && !dok) m_over = 1;
                if (rls) begin
                    void'(q.pop_front());
                    m_rd = (m_rd + 1) % LINES;
                end
                if (dok) begin
                    q.push_back(cur);
                    m_wr = (m_wr + 1) % LINES;
                    m_v = (m_v + 1) % 256;
                    m_req = 0;
                end
            end
            // one outstanding request whenever the ring has a vacancy
            exp_hs = (m_req == 0 && q.size() < LINES);
            if (exp_hs) m_req = 1;
            prev_lvbl = lvbl;
            prev_lhbl = lhbl;
        end
        #1;
        chk("ln_hs", {31'b0, ln_hs}, {31'b0, exp_hs});
        chk("ln_pxl", {16'b0, ln_pxl}, {16'b0, exp_pxl});
        chk("ln_v", {24'b0, ln_v}, 32'(m_v));
        chk("st_dout", {24'b0, st_dout}, {24'b0, exp_st});
        chk("hs_gap", {31'b0, ln_hs & prev_hs}, 32'd0);
        prev_hs = ln_hs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_line(input bit junk);
        for (int a = 0; a < HLEN; a++) begin
            ln_we = 1; ln_addr = HW'(a); ln_data = DW'($urandom);
            tick();
        end
        if (junk) for (int i = 0; i < 4; i++) begin
            ln_addr = HW'(HLEN + $urandom_range(0, 255)); ln_data = DW'($urandom);
            tick();
        end
        ln_we = 0;
    endtask

    task automatic done_line();
        ln_done = 1; tick(); ln_done = 0; idle(3);
    endtask

    task automatic active_line(input bit done_at_end);
        lhbl = 1; idle(2 * HLEN + 40);
        ln_done = done_at_end; lhbl = 0; tick(); ln_done = 0; idle(4);
    endtask

    task automatic read_st0();
        rd0 = 1; tick(); rd0 = 0; idle(2);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; rd0 = 0; prev_hs = 0;
        idle(3); rst = 0; idle(3);
        lvbl = 0; idle(4);
        for (int l = 0; l < LINES; l++) begin
            write_line(0);
            done_line();
        end
        write_line(1);
        done_line();
        read_st0();
        lvbl = 1; idle(2);
        active_line(0);
        write_line(1);
        done_line();
        active_line(0);
        active_line(0);
        write_line(0);
        active_line(1);
        active_line(0);
        active_line(0);
        read_st0();
        active_line(0);
        read_st0();
        lvbl = 0; idle(4);
        for (int a = 0; a < 101; a++) begin
            ln_we = 1; ln_addr = HW'(a); ln_data = DW'($urandom);
            if (a == 100) rst = 1;
            tick();
        end
        rst = 0; ln_we = 0; idle(3);
        lvbl = 1; idle(2);
        lvbl = 0; idle(4);
        write_line(0);
        done_line();
        lvbl = 1; idle(2);
        active_line(0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jtframe_lfbuf_ring.md
Name: jtframe_lfbuf_ring

Overview:
- Parametrised on-chip line buffer ring that replaces the two-line ping-pong in the line-frame buffer path.
- The game core renders whole lines into free slots through the ln_* interface. The block replays the oldest completed line, one pixel per pxl_cen, during active video.
- Ring depth, pixel width and line length are parameters. Over/underrun detection and a status port for the OSD debug view are added.
- Sits between the game instance and the video output inside the MiST/DECA top level.

Parameters:
- DW, 16, pixel data width.
- HW, 9, line address width (hdump/ln_addr).
- VW, 8, line counter width (ln_v).
- LINES, 4, ring depth in lines; power of two, at least 2.
- HLEN, 256, active pixels per line; must be at most 2^HW.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  synchronous, active-high reset.
- pxl_cen  in  1  pixel clock enable.
- lhbl  in  1  horizontal blank, active low.
- lvbl  in  1  vertical blank, active low.
- ln_addr  in  HW  game write address within the current line.
- ln_data  in  DW  game write data.
- ln_we  in  1  game write strobe.
- ln_done  in  1  one-cycle pulse: the current write line is complete.
- ln_hs  out  1  one-cycle pulse: a free slot exists; game must render line ln_v.
- ln_v  out  VW  line number the game must render next.
- ln_pxl  out  DW  displayed pixel.
- st_addr  in  8  status select.
- st_dout  out  8  status data.

Behaviour:
- Storage: LINES×HLEN words of DW bits, inferred BRAM.
- Write slot index wr_slot, read slot index rd_slot, occupancy fill in the range 0..LINES.
- Reset values: wr_slot=rd_slot=0, fill=0, ln_v=0, ln_pxl=0, st_dout=0, ln_hs=0, sticky flags cleared.
- Write path:
  - ln_we with fill<LINES and ln_addr<HLEN writes mem[wr_slot][ln_addr].
  - ln_we is ignored when fill==LINES or ln_addr>=HLEN.
- ln_done with fill<LINES:
  - wr_slot increments modulo LINES; fill increments; ln_v increments with wrap at 2^VW.
  - If fill<LINES-1 before the increment, ln_hs pulses on the next cycle.
- ln_done with fill==LINES is ignored and sets sticky overrun.
- Read path:
  - The horizontal counter hcnt clears on lhbl rising.
  - On each pxl_cen with lhbl=1 and lvbl=1, hcnt increments, saturating at HLEN-1.
  - Read address is mem[rd_slot][hcnt]. ln_pxl updates exactly one pxl_cen after the address is presented.
  - When fill==0 during active video, ln_pxl is driven to 0 and sticky underrun is set.
  - During blanking, ln_pxl holds 0.
- Line release:
  - On lhbl falling with lvbl=1 and fill>0, rd_slot increments modulo LINES and fill decrements.
  - The freed slot triggers an ln_hs pulse on the next cycle, unless a pulse was already issued for that vacancy.
- Simultaneous ln_done and release in the same cycle: fill is unchanged, both slot pointers advance, and ln_hs pulses once.
- Frame resync on lvbl falling:
  - wr_slot=rd_slot=0, fill=0, ln_v=0. Any partially written line is discarded.
  - ln_hs pulses on the next cycle, so the game pre-renders up to LINES lines during vblank.
- ln_hs timing: never asserted on two consecutive cycles; never asserted while fill==LINES.
- Status (registered, 1-cycle latency):
  - st_addr[1:0]=0 → {underrun, overrun, 2'b0, fill[3:0]}.
  - st_addr[1:0]=1 → ln_v[7:0].
  - st_addr[1:0]=2 → {wr_slot[3:0], rd_slot[3:0]}.
  - st_addr[1:0]=3 → 0.
  - Reading address 0 clears both sticky flags.
- Reset mid-line: all state returns to reset values on the next clock; memory contents are undefined, and because fill=0 they are never displayed.

Test Plan:
- Reset, then lvbl falling → ln_hs pulses once, ln_v=0, fill=0, ln_pxl=0.
- LINES=4: game writes lines with pixel value = {line, addr}, four ln_done pulses in vblank → three ln_hs pulses after the done pulses, fill=4, a 5th ln_done sets overrun (st_dout bit6=1).
- Active line after prefill: pixel k equals {0,k} one pxl_cen late. On lhbl falling, fill=3, rd_slot=1, ln_hs pulses, ln_v=4.
- No ln_done issued before an active line with fill=0 → ln_pxl stays 0 for the whole line, underrun=1. Reading st_addr=0 returns 8'h80, then the flags clear.
- ln_done and lhbl falling in the same cycle with fill=2 → fill stays 2, both slots advance, exactly one ln_hs pulse.
- Assert rst in the middle of a line write (ln_addr=100) → next cycle all outputs are at reset values; after the next lvbl falling, line 0 is re-requested.
